// File: rtl/pulse_interval_meter.sv
// Measures the number of clk cycles between consecutive rising edges of a synchronized pulse.
// It keeps a running edge count and offers each interval through a one-deep valid/ready register.
module pulse_interval_meter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pulse_in,
  input  logic             clr,
  output logic [CNT_W-1:0] interval,
  output logic             int_valid,
  input  logic             int_ready,
  output logic             ovf,
  output logic [CNT_W-1:0] pulse_cnt,
  output logic             armed
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] interval_q, interval_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             edge_s;
  logic             res_done_s;

  assign edge_s = pulse_in & ~pulse_q;

  // Next-state logic: clear first, then edge FSM, then the output register.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    interval_d = interval_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;
    pcnt_d     = pcnt_q;
    res_done_s = 1'b0;
    if (clr) begin
      state_d    = ST_IDLE;
      cnt_d      = CNT_ZERO;
      interval_d = CNT_ZERO;
      valid_d    = 1'b0;
      ovf_d      = 1'b0;
      pcnt_d     = CNT_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (edge_s) begin
            state_d = ST_MEASURE;
            cnt_d   = CNT_ONE;
            pcnt_d  = pcnt_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_MEASURE: begin
          if (edge_s) begin
            res_done_s = 1'b1;
            cnt_d      = CNT_ONE;
            pcnt_d     = pcnt_q + CNT_ONE;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase

      // A full register that is being drained this cycle can take the new result.
      if (res_done_s) begin
        if (!valid_q || int_ready) begin
          interval_d = cnt_q;
          valid_d    = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (valid_q && int_ready) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
    end
  end

  // State and output registers; the edge-detect delay tracks pulse_in even during clr.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      pulse_q    <= 1'b0;
      cnt_q      <= CNT_ZERO;
      interval_q <= CNT_ZERO;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      pcnt_q     <= CNT_ZERO;
    end else begin
      state_q    <= state_d;
      pulse_q    <= pulse_in;
      cnt_q      <= cnt_d;
      interval_q <= interval_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      pcnt_q     <= pcnt_d;
    end
  end

  assign interval  = interval_q;
  assign int_valid = valid_q;
  assign ovf       = ovf_q;
  assign pulse_cnt = pcnt_q;
  assign armed     = (state_q == ST_MEASURE);

endmodule

// File: doc/pulse_interval_meter.md
# pulse_interval_meter

Fast-domain measurement stage that sits directly downstream of the slow-to-fast pulse synchronizer and consumes its single-bit output pulse. It detects rising edges of the synchronized pulse and measures the distance, in clock cycles, between consecutive edges. It keeps a running edge count. Each completed interval is offered to the consumer through a one-deep valid/ready output register, with a sticky overflow flag when a result is dropped.

## Interface

- CNT_W, 16: width of the interval counter, `interval` and `pulse_cnt`; legal range 4–32.
- clk  in  1  fast-domain clock; all logic on its rising edge.
- rstn  in  1  asynchronous active-low reset; release is synchronous to clk upstream.
- pulse_in  in  1  synchronized pulse from the slow-to-fast stage, already in the clk domain; may be high 1..N cycles.
- clr  in  1  synchronous clear of all measurement state.
- interval  out  CNT_W  last measured edge-to-edge distance in clk cycles; saturates at 2^CNT_W-1.
- int_valid  out  1  `interval` holds an unconsumed result.
- int_ready  in  1  consumer accepts `interval` when high together with `int_valid`.
- ovf  out  1  sticky; a completed interval was dropped because the output register was full.
- pulse_cnt  out  CNT_W  total rising edges seen since reset/clr; wraps modulo 2^CNT_W.
- armed  out  1  first edge seen; measurement in progress.

## Operation

- Edge detect: the block has a register `pulse_d` (reset 0). `edge = pulse_in & ~pulse_d`. `pulse_d` updates every cycle, including during clr. A level held high counts once.
- FSM, two states:
  - IDLE (reset state, `armed`=0). On edge: go to MEASURE, cnt<=1, pulse_cnt+1. No interval is produced.
  - MEASURE (`armed`=1). On edge: capture current cnt as the result, cnt<=1, pulse_cnt+1. Otherwise cnt<=cnt+1, saturating at 2^CNT_W-1 and holding there.
- Output register, evaluated in priority order:
  1. Result completes and (`int_valid`=0 or `int_ready`=1): `interval`<=cnt and `int_valid`<=1. This includes the simultaneous accept-and-load case, where `int_valid` stays 1.
  2. Result completes and `int_valid`=1 and `int_ready`=0: the new result is discarded, the old `interval` is held, and `ovf`<=1.
  3. No result and `int_valid` & `int_ready`: `int_valid`<=0, and `interval` keeps its last value.
- clr has priority over everything. State<=IDLE, cnt<=0, `int_valid`<=0, `ovf`<=0, `pulse_cnt`<=0, `interval`<=0. An edge in the same cycle is ignored and not counted.
- `interval` is stable while `int_valid`=1 and `int_ready`=0.
- `pulse_cnt` wraps from 2^CNT_W-1 to 0 with no flag.

## Timing

- Reset values: `interval`=0, `int_valid`=0, `ovf`=0, `pulse_cnt`=0, `armed`=0, internal cnt=0, `pulse_d`=0, state IDLE.
- If `pulse_in`=1 at the first clock after reset release, that counts as an edge.
- Latency: `pulse_in` sampled high at clock k, with k-1 sampled low.
  - `armed`, `pulse_cnt` and, if applicable, `interval`/`int_valid` reflect it from clock k onward (registered, 1-cycle).
- Interval definition: edges sampled at clocks t0 < t1 give `interval` = t1 - t0. The minimum is 2, because back-to-back edges are impossible.
- Handshake: a transfer occurs on a clock where `int_valid` & `int_ready`. `int_ready` may be held high permanently. `int_valid` never depends combinationally on `int_ready`.
- Reset asserted mid-measurement: all outputs return to reset values immediately (asynchronous). The pending result is lost and `ovf` is not set.

## Test plan

- Reset and arm: hold rstn=0 for 3 cycles, all outputs 0. Pulse `pulse_in` high 1 cycle at clock 5 -> `armed`=1 and `pulse_cnt`=1 from clock 5, `int_valid` stays 0.
- Basic interval, `int_ready`=1: edges at clocks 5, 14 and 17 -> `interval`=9 with `int_valid` at clock 14, then `interval`=3 at clock 17, `pulse_cnt`=3, `ovf`=0.
- Multi-cycle level and minimum gap: `pulse_in` high clocks 10–13 -> one edge only (`pulse_cnt`+1). Low at 14, high at 15 -> `interval`=5.
- Backpressure/overflow: `int_ready`=0, edges at 5, 10, 20 -> `interval`=5 held, `ovf`=1 at clock 20. Then `int_ready`=1 for 1 cycle -> `int_valid`=0 next clock, `ovf` remains 1. Also cover simultaneous accept-and-load: `int_valid` stays 1 with the new value.
- Saturation and wrap: CNT_W=4, edges 40 cycles apart -> `interval`=15. 17 edges -> `pulse_cnt`=1.
- clr and async reset mid-operation: clr coincident with an edge -> edge not counted, all state cleared, `armed`=0. rstn pulsed low between two edges -> outputs 0 immediately, and the next edge only re-arms.
